ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the 5-stage RV32 pipeline: selects the second ALU operand, computes single-cycle ALU results and, optionally, RV32M multiply/divide results through an iterative 32-step unit. Drives the EX/MEM pipeline register that feeds the memory stage. Stalls upstream stages while a multi-cycle operation is in flight.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_n_i  in  1  reset; asynchronous, active-low.
- valid_i  in  1  ID/EX holds a real instruction.
- flush_i  in  1  kill the instruction in EX, including an in-flight mul/div.
- ALUctrl_i  in  5  operation code, encodings in ex_pkg.
- ALUsrc_i  in  1  0: op2 = regOp2_i; 1: op2 = ImmOp_i.
- regOp1_i, regOp2_i, ImmOp_i, pcPlus4_i  in  32 each  operands and forwarded fields.
- RegWrite_i, MemWrite_i  in  1 each; WriteSrc_i  in  2; rd_i  in  5  control forwarded to MEM.
- stall_o  out  1  upstream must hold PC, IF/ID and ID/EX.
- RegWrite_o, MemWrite_o  out  1 each; WriteSrc_o  out  2; rd_o  out  5  registered control.
- ALUout_o, regOp2_o, pcPlus4_o, ImmOp_o  out  32 each  registered data for MEM.

## Operation
- Base ops (ALUctrl_i[4]=0): ADD 0x00, SUB 0x01, AND 0x02, OR 0x03, XOR 0x04, SLL 0x05, SRL 0x06, SRA 0x07, SLT 0x08, SLTU 0x09, PASSB 0x0A (result = op2); 0x0B–0x0F give result 0.
- Shifts use op2[4:0]; ADD/SUB wrap modulo 2^32; SLT/SLTU produce 0 or 1.
- M ops (ALUctrl_i[4]=1): MUL 0x10, MULH 0x11, MULHSU 0x12, MULHU 0x13, DIV 0x14, DIVU 0x15, REM 0x16, REMU 0x17; 0x18–0x1F give result 0, single-cycle.
- Signed mul/div: operate on magnitudes, fix sign at the end. Multiply: shift-add, 64-bit product. Divide: restoring, one quotient bit per step.
- Divide by zero: quotient 0xFFFFFFFF, remainder = dividend. Overflow (0x80000000 / -1): quotient 0x80000000, remainder 0.
- FSM: IDLE -> BUSY on a valid M op (operands latched, count=31); BUSY decrements count, and at count==0 goes to DONE; DONE -> IDLE after the result is captured.
- stall_o = (IDLE and valid_i and M op and not flush_i) or BUSY.
- EX/MEM register: when stall_o=1, flush_i=1 or valid_i=0, it loads a bubble (RegWrite_o=0, MemWrite_o=0, other fields don't-care and hold). Otherwise it captures the result and the forwarded fields.
- flush_i in any state forces IDLE and a bubble.

## Timing
- Reset: FSM IDLE, count 0, all outputs 0, stall_o 0.
- Base op: presented in cycle C, visible on outputs after the C edge (latency 1, no stall).
- M op presented in cycle C:
  - stall_o is high in C..C+32 and low in C+33 (DONE).
  - The result is registered at the end of C+33; upstream advances on that same edge.
  - Bubbles are issued on the edges ending C..C+32.
- Back-to-back M ops: DONE -> IDLE, and the next M op starts the following cycle with no extra gap.
- Reset or flush mid-operation: the partial result is discarded and no write reaches MEM.

## Configuration
- EX_MULDIV_EN defined: the M ops and the FSM above are built.
- EX_MULDIV_EN undefined: no mul/div logic and no FSM. ALUctrl_i 0x10–0x1F give result 0 in a single cycle, and stall_o is tied to 0.

## Structure
- Package ex_pkg holds:
  - the alu_op_e enum (all encodings above);
  - the muldiv_state_e enum (IDLE, BUSY, DONE);
  - MULDIV_STEPS = 32 and the div-by-zero/overflow result constants.
- Sub-module muldiv_unit holds the FSM, counter, operand/accumulator registers and sign fix-up, with a start/done handshake. It is instantiated only under EX_MULDIV_EN.
- ex_stage holds the operand mux, the combinational ALU and the EX/MEM register.

## Test plan
- ADD with ALUsrc_i=1, regOp1=5, Imm=0xFFFFFFFF -> ALUout_o=4 one cycle later, stall_o never high.
- SRA regOp1=0x80000000, op2=4 -> 0xF8000000; SLTU 1 vs 0xFFFFFFFF -> 1.
- MULH 0xFFFFFFFF × 0xFFFFFFFF -> 0; MULHU same operands -> 0xFFFFFFFE. For both:
  - stall_o high exactly 33 cycles;
  - RegWrite_o=0 during the stall;
  - the result is registered in cycle 34.
- DIV 7 / 0 -> 0xFFFFFFFF; REM 7 / 0 -> 7; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -7 / 2 -> 0xFFFFFFFF.
- flush_i at BUSY cycle 10 of a DIVU -> FSM IDLE next cycle, stall_o low, no RegWrite_o pulse. rst_n_i pulsed mid-MUL -> all outputs 0 immediately.
- With EX_MULDIV_EN undefined: MUL 3×4 -> ALUout_o=0, stall_o=0, latency 1.

Source files
------------

// File: rtl/ex_pkg.sv
// ex_pkg: operation encodings, mul/div FSM states and mul/div result constants
package ex_pkg;
  localparam int MULDIV_STEPS = 32;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] DIV_OVF_Q = 32'h8000_0000;
  localparam logic [31:0] DIV_OVF_R = 32'h0000_0000;
  typedef enum logic [4:0] {
    ALU_ADD    = 5'h00,
    ALU_SUB    = 5'h01,
    ALU_AND    = 5'h02,
    ALU_OR     = 5'h03,
    ALU_XOR    = 5'h04,
    ALU_SLL    = 5'h05,
    ALU_SRL    = 5'h06,
    ALU_SRA    = 5'h07,
    ALU_SLT    = 5'h08,
    ALU_SLTU   = 5'h09,
    ALU_PASSB  = 5'h0A,
    ALU_MUL    = 5'h10,
    ALU_MULH   = 5'h11,
    ALU_MULHSU = 5'h12,
    ALU_MULHU  = 5'h13,
    ALU_DIV    = 5'h14,
    ALU_DIVU   = 5'h15,
    ALU_REM    = 5'h16,
    ALU_REMU   = 5'h17
  } alu_op_e;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} muldiv_state_e;
  function automatic logic [31:0] mag(input logic [31:0] v, input logic s);
    return (s && v[31]) ? -v : v;
  endfunction
endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX inputs and EX/MEM outputs of the execute stage
interface ex_stage_if #(parameter int XLEN = 32);
  logic            valid_i;
  logic            flush_i;
  logic [4:0]      ALUctrl_i;
  logic            ALUsrc_i;
  logic [XLEN-1:0] regOp1_i;
  logic [XLEN-1:0] regOp2_i;
  logic [XLEN-1:0] ImmOp_i;
  logic [XLEN-1:0] pcPlus4_i;
  logic            RegWrite_i;
  logic            MemWrite_i;
  logic [1:0]      WriteSrc_i;
  logic [4:0]      rd_i;
  logic            stall_o;
  logic            RegWrite_o;
  logic            MemWrite_o;
  logic [1:0]      WriteSrc_o;
  logic [4:0]      rd_o;
  logic [XLEN-1:0] ALUout_o;
  logic [XLEN-1:0] regOp2_o;
  logic [XLEN-1:0] pcPlus4_o;
  logic [XLEN-1:0] ImmOp_o;
  modport master (
    output valid_i, flush_i, ALUctrl_i, ALUsrc_i, regOp1_i, regOp2_i, ImmOp_i, pcPlus4_i,
           RegWrite_i, MemWrite_i, WriteSrc_i, rd_i,
    input  stall_o, RegWrite_o, MemWrite_o, WriteSrc_o, rd_o, ALUout_o, regOp2_o, pcPlus4_o, ImmOp_o
  );
  modport slave (
    input  valid_i, flush_i, ALUctrl_i, ALUsrc_i, regOp1_i, regOp2_i, ImmOp_i, pcPlus4_i,
           RegWrite_i, MemWrite_i, WriteSrc_i, rd_i,
    output stall_o, RegWrite_o, MemWrite_o, WriteSrc_o, rd_o, ALUout_o, regOp2_o, pcPlus4_o, ImmOp_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-step shift-add multiplier / restoring divider with sign fix-up
module muldiv_unit
  import ex_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start,
  input  logic        flush,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        idle,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);
  muldiv_state_e state, state_n;
  logic [4:0] count;
  logic [2:0] op_q;
  logic [31:0] m, hi, lo, quo, rem;
  logic a_neg, b_neg, div0, ovf, sa, sb;
  logic [32:0] sum, diff;
  logic [63:0] prod;
  always_comb begin
    sa = op[2] ? !op[0] : op != 3'd3;
    sb = op[2] ? !op[0] : !op[1];
    state_n = flush ? IDLE :
              state == IDLE ? (start ? BUSY : IDLE) :
              state == BUSY ? (count == 5'd0 ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) state <= IDLE;
    else state <= state_n;
  // hi:lo is the product for multiply, remainder:quotient for divide
  always_comb begin
    sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : 33'd0);
    diff = {hi, lo[31]} - {1'b0, m};
    prod = (a_neg ^ b_neg) ? -{hi, lo} : {hi, lo};
    quo = div0 ? DIV_ZERO_Q : ovf ? DIV_OVF_Q : (a_neg ^ b_neg) ? -lo : lo;
    rem = ovf ? DIV_OVF_R : a_neg ? -hi : hi;
    result = op_q[2] ? (op_q[1] ? rem : quo) : (op_q[1:0] == 2'd0 ? prod[31:0] : prod[63:32]);
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      count <= '0;
      op_q <= '0;
      m <= '0;
      hi <= '0;
      lo <= '0;
      a_neg <= 1'b0;
      b_neg <= 1'b0;
      div0 <= 1'b0;
      ovf <= 1'b0;
    end else if (state == IDLE && start) begin
      count <= 5'(MULDIV_STEPS - 1);
      op_q <= op;
      a_neg <= sa & a[31];
      b_neg <= sb & b[31];
      div0 <= op[2] && b == '0;
      ovf <= op[2] && !op[0] && a == 32'h8000_0000 && b == '1;
      hi <= '0;
      m <= op[2] ? mag(b, sb) : mag(a, sa);
      lo <= op[2] ? mag(a, sa) : mag(b, sb);
    end else if (state == BUSY) begin
      count <= count - 5'd1;
      hi <= op_q[2] ? (diff[32] ? {hi[30:0], lo[31]} : diff[31:0]) : sum[32:1];
      lo <= op_q[2] ? {lo[30:0], !diff[32]} : {sum[0], lo[31:1]};
    end
  assign idle = state == IDLE;
  assign busy = state == BUSY;
  assign done = state == DONE;
endmodule

// File: rtl/ex_stage.sv
// ex_stage: RV32 execute stage, operand mux + ALU + EX/MEM register
// EX_MULDIV_EN builds the iterative RV32M unit; otherwise 0x10-0x1F yield 0 with no stall.
module ex_stage
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic       clk_i,
  input logic       rst_n_i,
  ex_stage_if.slave bus
);
  logic [XLEN-1:0] a, op2, alu, res;
  logic stall, md_ok;
  assign a = bus.regOp1_i;
  assign op2 = bus.ALUsrc_i ? bus.ImmOp_i : bus.regOp2_i;
  always_comb begin
    alu = '0;
    case (bus.ALUctrl_i)
      ALU_ADD:   alu = a + op2;
      ALU_SUB:   alu = a - op2;
      ALU_AND:   alu = a & op2;
      ALU_OR:    alu = a | op2;
      ALU_XOR:   alu = a ^ op2;
      ALU_SLL:   alu = a << op2[4:0];
      ALU_SRL:   alu = a >> op2[4:0];
      ALU_SRA:   alu = $signed(a) >>> op2[4:0];
      ALU_SLT:   alu = {{(XLEN-1){1'b0}}, $signed(a) < $signed(op2)};
      ALU_SLTU:  alu = {{(XLEN-1){1'b0}}, a < op2};
      ALU_PASSB: alu = op2;
      default:   alu = '0;
    endcase
  end
`ifdef EX_MULDIV_EN
  logic m_op, md_idle, md_busy, md_done;
  logic [XLEN-1:0] md_res;
  assign m_op = bus.ALUctrl_i[4] && !bus.ALUctrl_i[3];
  muldiv_unit u_muldiv (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .start   (bus.valid_i && m_op && !bus.flush_i),
    .flush   (bus.flush_i),
    .op      (bus.ALUctrl_i[2:0]),
    .a       (a),
    .b       (op2),
    .idle    (md_idle),
    .busy    (md_busy),
    .done    (md_done),
    .result  (md_res)
  );
  assign stall = (md_idle && bus.valid_i && m_op && !bus.flush_i) || md_busy;
  assign res = m_op ? md_res : alu;
  assign md_ok = !m_op || md_done;
`else
  assign stall = 1'b0;
  assign res = alu;
  assign md_ok = 1'b1;
`endif
  assign bus.stall_o = stall;
  // bubbles only clear the write enables; data fields hold
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      bus.RegWrite_o <= 1'b0;
      bus.MemWrite_o <= 1'b0;
      bus.WriteSrc_o <= '0;
      bus.rd_o <= '0;
      bus.ALUout_o <= '0;
      bus.regOp2_o <= '0;
      bus.pcPlus4_o <= '0;
      bus.ImmOp_o <= '0;
    end else if (stall || bus.flush_i || !bus.valid_i || !md_ok) begin
      bus.RegWrite_o <= 1'b0;
      bus.MemWrite_o <= 1'b0;
    end else begin
      bus.RegWrite_o <= bus.RegWrite_i;
      bus.MemWrite_o <= bus.MemWrite_i;
      bus.WriteSrc_o <= bus.WriteSrc_i;
      bus.rd_o <= bus.rd_i;
      bus.ALUout_o <= res;
      bus.regOp2_o <= bus.regOp2_i;
      bus.pcPlus4_o <= bus.pcPlus4_i;
      bus.ImmOp_o <= bus.ImmOp_i;
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed-vector bench for ex_stage (base ALU always; RV32M when EX_MULDIV_EN)
module tb_ex_stage;
  import ex_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  int vecs = 0;
  int errs = 0;
  always #5 clk = ~clk;
  ex_stage_if bus ();
  ex_stage dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [4:0] op, input logic src, input logic [31:0] a, b, imm);
    bus.valid_i = 1'b1;
    bus.flush_i = 1'b0;
    bus.ALUctrl_i = op;
    bus.ALUsrc_i = src;
    bus.regOp1_i = a;
    bus.regOp2_i = b;
    bus.ImmOp_i = imm;
  endtask
  task automatic base(input string tag, input logic [4:0] op, input logic src,
                      input logic [31:0] a, b, imm, exp);
    drive(op, src, a, b, imm);
    #1;
    chk({tag, " stall"}, 32'(bus.stall_o), 32'd0);
    @(posedge clk);
    #1;
    chk(tag, bus.ALUout_o, exp);
    chk({tag, " we"}, 32'(bus.RegWrite_o), 32'd1);
  endtask
`ifdef EX_MULDIV_EN
  task automatic mop(input string tag, input logic [4:0] op, input logic [31:0] a, b, exp);
    int n;
    logic bad;
    n = 0;
    bad = 1'b0;
    drive(op, 1'b0, a, b, 32'd0);
    #1;
    while (bus.stall_o && n < 40) begin
      n++;
      @(posedge clk);
      #1;
      if (bus.RegWrite_o !== 1'b0) bad = 1'b1;
    end
    chk({tag, " stall cycles"}, 32'(n), 32'd33);
    chk({tag, " bubble we"}, 32'(bad), 32'd0);
    @(posedge clk);
    #1;
    chk(tag, bus.ALUout_o, exp);
    chk({tag, " we"}, 32'(bus.RegWrite_o), 32'd1);
  endtask
`endif
  initial begin
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.ALUctrl_i = '0;
    bus.ALUsrc_i = 1'b0;
    bus.regOp1_i = '0;
    bus.regOp2_i = '0;
    bus.ImmOp_i = '0;
    bus.pcPlus4_i = '0;
    bus.RegWrite_i = 1'b0;
    bus.MemWrite_i = 1'b0;
    bus.WriteSrc_i = '0;
    bus.rd_i = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst aluout", bus.ALUout_o, 32'd0);
    chk("rst we", 32'(bus.RegWrite_o), 32'd0);
    chk("rst memwrite", 32'(bus.MemWrite_o), 32'd0);
    chk("rst rd", 32'(bus.rd_o), 32'd0);
    chk("rst stall", 32'(bus.stall_o), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    bus.RegWrite_i = 1'b1;
    bus.MemWrite_i = 1'b1;
    bus.WriteSrc_i = 2'd2;
    bus.rd_i = 5'd17;
    bus.pcPlus4_i = 32'h0000_0104;
    base("add imm", ALU_ADD, 1'b1, 32'd5, 32'hCAFE_0000, 32'hFFFF_FFFF, 32'd4);
    chk("fwd memwrite", 32'(bus.MemWrite_o), 32'd1);
    chk("fwd writesrc", 32'(bus.WriteSrc_o), 32'd2);
    chk("fwd rd", 32'(bus.rd_o), 32'd17);
    chk("fwd pc4", bus.pcPlus4_o, 32'h0000_0104);
    chk("fwd imm", bus.ImmOp_o, 32'hFFFF_FFFF);
    chk("fwd op2", bus.regOp2_o, 32'hCAFE_0000);
    bus.MemWrite_i = 1'b0;
    base("sub", ALU_SUB, 1'b0, 32'd3, 32'd5, 32'd0, 32'hFFFF_FFFE);
    base("and", ALU_AND, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 32'h00F0_1200);
    base("or", ALU_OR, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 32'hFFF0_FF34);
    base("xor", ALU_XOR, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0, 32'hFF00_ED34);
    base("sll", ALU_SLL, 1'b1, 32'd1, 32'd0, 32'h0000_003F, 32'h8000_0000);
    base("srl", ALU_SRL, 1'b0, 32'h8000_0000, 32'd4, 32'd0, 32'h0800_0000);
    base("sra", ALU_SRA, 1'b0, 32'h8000_0000, 32'd4, 32'd0, 32'hF800_0000);
    base("slt", ALU_SLT, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1);
    base("sltu", ALU_SLTU, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd1);
    base("sltu rev", ALU_SLTU, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    base("passb", ALU_PASSB, 1'b0, 32'd9, 32'h1234_5678, 32'd0, 32'h1234_5678);
    drive(ALU_SUB, 1'b0, 32'd9, 32'd1, 32'd0);
    bus.valid_i = 1'b0;
    @(posedge clk);
    #1;
    chk("invalid we", 32'(bus.RegWrite_o), 32'd0);
    chk("invalid hold", bus.ALUout_o, 32'h1234_5678);
    drive(ALU_ADD, 1'b0, 32'd1, 32'd1, 32'd0);
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1;
    chk("flush we", 32'(bus.RegWrite_o), 32'd0);
    base("op 0b", 5'h0B, 1'b0, 32'd7, 32'd3, 32'd0, 32'd0);
`ifdef EX_MULDIV_EN
    mop("mulh", ALU_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    mop("mulhu", ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    mop("mul", ALU_MUL, 32'd3, 32'd4, 32'd12);
    mop("mulhsu", ALU_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
    mop("div by 0", ALU_DIV, 32'd7, 32'd0, 32'hFFFF_FFFF);
    mop("rem by 0", ALU_REM, 32'd7, 32'd0, 32'd7);
    mop("div ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    mop("rem neg", ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    mop("div neg", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    mop("remu", ALU_REMU, 32'd100, 32'd7, 32'd2);
    drive(ALU_DIVU, 1'b0, 32'd100, 32'd7, 32'd0);
    repeat (11) begin
      @(posedge clk);
      #1;
    end
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    #1;
    chk("post flush stall", 32'(bus.stall_o), 32'd0);
    chk("post flush we", 32'(bus.RegWrite_o), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("post flush quiet", 32'(bus.RegWrite_o), 32'd0);
    mop("divu after flush", ALU_DIVU, 32'd100, 32'd7, 32'd14);
`else
    base("mul off", ALU_MUL, 1'b0, 32'd3, 32'd4, 32'd0, 32'd0);
    base("div off", ALU_DIV, 1'b0, 32'd7, 32'd0, 32'd0, 32'd0);
`endif
    base("add pre rst", ALU_ADD, 1'b0, 32'd5, 32'd7, 32'd0, 32'd12);
`ifdef EX_MULDIV_EN
    drive(ALU_MUL, 1'b0, 32'd3, 32'd4, 32'd0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
`endif
    rst_n = 1'b0;
    bus.valid_i = 1'b0;
    #1;
    chk("midrst aluout", bus.ALUout_o, 32'd0);
    chk("midrst we", 32'(bus.RegWrite_o), 32'd0);
    chk("midrst rd", 32'(bus.rd_o), 32'd0);
    chk("midrst pc4", bus.pcPlus4_o, 32'd0);
    chk("midrst stall", 32'(bus.stall_o), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    base("add post rst", ALU_ADD, 1'b0, 32'd40, 32'd2, 32'd0, 32'd42);
`ifdef EX_MULDIV_EN
    mop("mul post rst", ALU_MUL, 32'd3, 32'd4, 32'd12);
`endif
    bus.valid_i = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
